// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard/stall controller.
// Drives the stall and flush controls of the IF/ID, ID/EX and EX/MEM
// registers, sequences branch flushes and data-memory waits, and selects
// operand forwarding sources.
// Optional feature macro: HAZARD_FWD_EN. When it is defined, EX/MEM and
// MEM/WB forwarding is enabled and only load-use conflicts stall. When it
// is undefined, every EX or MEM producer conflict stalls and the forwarding
// selects stay 0.
// Handshake note: the controller has no valid/ready interface. Every
// output is a level that applies to the current cycle only, is computed
// from the registered state and the current inputs, and is held low while
// rst_n is low.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int REG_ADDR_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_write_en_i,
    input  logic                  ex_load_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_write_en_i,
    input  logic                  branch_taken_i,
    input  logic                  mem_busy_i,
    output logic                  stall_if_o,
    output logic                  stall_id_o,
    output logic                  stall_ex_o,
    output logic                  flush_id_o,
    output logic                  flush_ex_o,
    output logic [1:0]            fwd_a_sel_o,
    output logic [1:0]            fwd_b_sel_o,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    // Value loaded into the counter when a taken branch is seen; the
    // branch cycle itself is the first flushed cycle.
    localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic       ex_a, ex_b, mem_a, mem_b;
    logic       data_hazard;
    logic [1:0] fwd_a, fwd_b;
    logic       s_if, s_id, s_ex, f_id, f_ex;

    // A register index of 0 is hardwired to zero and never creates a hazard.
    function automatic logic src_match(input logic used, input logic we,
                                       input logic [REG_ADDR_W-1:0] rd,
                                       input logic [REG_ADDR_W-1:0] src);
        return used && we && (rd != '0) && (rd == src);
    endfunction

    // Source/destination comparisons, hazard detection and forwarding select.
    always_comb begin
        ex_a  = src_match(id_rs1_used_i, ex_write_en_i, ex_rd_i, id_rs1_i);
        ex_b  = src_match(id_rs2_used_i, ex_write_en_i, ex_rd_i, id_rs2_i);
        mem_a = src_match(id_rs1_used_i, mem_write_en_i, mem_rd_i, id_rs1_i);
        mem_b = src_match(id_rs2_used_i, mem_write_en_i, mem_rd_i, id_rs2_i);
`ifdef HAZARD_FWD_EN
        // Only a load in EX cannot be forwarded in time; EX wins over MEM.
        data_hazard = ex_load_i && (ex_a || ex_b);
        fwd_a = ex_a ? 2'd1 : (mem_a ? 2'd2 : 2'd0);
        fwd_b = ex_b ? 2'd1 : (mem_b ? 2'd2 : 2'd0);
`else
        // Without forwarding the consumer waits until the producer has
        // written back: two bubbles from EX, one from MEM.
        data_hazard = ex_a || ex_b || mem_a || mem_b;
        fwd_a = 2'd0;
        fwd_b = 2'd0;
`endif
    end

    // State and flush counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and control outputs; priority is mem_busy, then branch,
    // then data hazard. MEM_WAIT with memory ready behaves exactly as RUN so
    // a branch held in the stalled EX stage is serviced on that cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_if    = 1'b0;
        s_id    = 1'b0;
        s_ex    = 1'b0;
        f_id    = 1'b0;
        f_ex    = 1'b0;
        case (state_q)
            FLUSH: begin
                if (mem_busy_i) begin
                    // Memory wait takes over; the remaining flush is dropped.
                    s_if    = 1'b1;
                    s_id    = 1'b1;
                    s_ex    = 1'b1;
                    state_d = MEM_WAIT;
                    cnt_d   = 3'd0;
                end else if (branch_taken_i) begin
                    f_id    = 1'b1;
                    f_ex    = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = (CNT_LOAD == 3'd0) ? RUN : FLUSH;
                end else begin
                    f_id  = 1'b1;
                    f_ex  = 1'b1;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = RUN;
                        cnt_d   = 3'd0;
                    end
                end
            end
            default: begin
                if (mem_busy_i) begin
                    s_if    = 1'b1;
                    s_id    = 1'b1;
                    s_ex    = 1'b1;
                    state_d = MEM_WAIT;
                end else if (branch_taken_i) begin
                    f_id    = 1'b1;
                    f_ex    = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = (CNT_LOAD == 3'd0) ? RUN : FLUSH;
                end else if (data_hazard) begin
                    // Hold IF and ID, push a bubble into EX, let EX drain.
                    s_if    = 1'b1;
                    s_id    = 1'b1;
                    f_ex    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = RUN;
                end
            end
        endcase
    end

    // All controls are forced inactive while reset is asserted.
    always_comb begin
        stall_if_o  = rst_n & s_if;
        stall_id_o  = rst_n & s_id;
        stall_ex_o  = rst_n & s_ex;
        flush_id_o  = rst_n & f_id;
        flush_ex_o  = rst_n & f_ex;
        fwd_a_sel_o = rst_n ? fwd_a : 2'd0;
        fwd_b_sel_o = rst_n ? fwd_b : 2'd0;
        dbg_state   = state_q;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl built with FLUSH_CYCLES=3.
// Expectations follow HAZARD_FWD_EN when the macro is defined.
module tb_hazard_ctrl;

    localparam int W = 9;

`ifdef HAZARD_FWD_EN
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
`else
    localparam logic [1:0] FWD_EX  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic       id_rs1_used, id_rs2_used, ex_write_en, ex_load, mem_write_en;
    logic       branch_taken, mem_busy;
    logic       stall_if, stall_id, stall_ex, flush_id, flush_ex;
    logic [1:0] fwd_a_sel, fwd_b_sel, dbg_state;

    logic [W-1:0] exp_q[$];
    int           vectors = 0;
    int           miscompares = 0;

    hazard_ctrl #(.FLUSH_CYCLES(3), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .ex_rd_i(ex_rd), .ex_write_en_i(ex_write_en), .ex_load_i(ex_load),
        .mem_rd_i(mem_rd), .mem_write_en_i(mem_write_en),
        .branch_taken_i(branch_taken), .mem_busy_i(mem_busy),
        .stall_if_o(stall_if), .stall_id_o(stall_id), .stall_ex_o(stall_ex),
        .flush_id_o(flush_id), .flush_ex_o(flush_ex),
        .fwd_a_sel_o(fwd_a_sel), .fwd_b_sel_o(fwd_b_sel),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ev(input logic sif, input logic sid,
                                        input logic sex, input logic fid,
                                        input logic fex, input logic [1:0] fa,
                                        input logic [1:0] fb);
        return {sif, sid, sex, fid, fex, fa, fb};
    endfunction

    localparam logic [W-1:0] NONE = '0;
    localparam logic [W-1:0] FL   = 9'b00011_00_00;
    localparam logic [W-1:0] ST   = 9'b11100_00_00;
    localparam logic [W-1:0] BUB  = 9'b11001_00_00;

    task automatic clr();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rd = 5'd0; ex_write_en = 1'b0; ex_load = 1'b0;
        mem_rd = 5'd0; mem_write_en = 1'b0;
        branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    // Push the expectation for the cycle being driven, check it at the
    // falling edge, then advance to just after the next rising edge.
    task automatic step(input logic [W-1:0] e, input string tag);
        logic [W-1:0] got, want;
        exp_q.push_back(e);
        @(negedge clk);
        got  = {stall_if, stall_id, stall_ex, flush_id, flush_ex, fwd_a_sel, fwd_b_sel};
        want = exp_q.pop_front();
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, got, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input logic [1:0] e, input string tag);
        @(negedge clk);
        vectors++;
        assert (dbg_state === e) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, dbg_state, e);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        check_state(2'd0, "reset_state");
        step(NONE, "reset_outputs");
        rst_n = 1'b1;
        step(NONE, "idle");

        // Reset asserted mid-flush while a branch is still presented
        branch_taken = 1'b1;
        step(FL, "rst_branch");
        rst_n = 1'b0;
        step(NONE, "rst_mid_flush");
        rst_n = 1'b1;
        branch_taken = 1'b0;
        check_state(2'd0, "rst_release_state");
        step(NONE, "rst_release_noflush");

        // Single branch: three flush cycles
        branch_taken = 1'b1;
        step(FL, "br1_c0");
        branch_taken = 1'b0;
        step(FL, "br1_c1");
        step(FL, "br1_c2");
        step(NONE, "br1_c3");

        // Second branch at cycle 2 extends flush through cycle 4
        branch_taken = 1'b1;
        step(FL, "br2_c0");
        branch_taken = 1'b0;
        step(FL, "br2_c1");
        branch_taken = 1'b1;
        step(FL, "br2_c2");
        branch_taken = 1'b0;
        step(FL, "br2_c3");
        step(FL, "br2_c4");
        step(NONE, "br2_c5");

        // ALU producer in EX, consumer rs1
        ex_rd = 5'd7; ex_write_en = 1'b1; id_rs1 = 5'd7; id_rs1_used = 1'b1;
`ifdef HAZARD_FWD_EN
        step(ev(0, 0, 0, 0, 0, 2'd1, 2'd0), "alu_ex_fwd");
`else
        step(BUB, "alu_ex_bubble1");
`endif
        ex_rd = 5'd0; ex_write_en = 1'b0; mem_rd = 5'd7; mem_write_en = 1'b1;
`ifdef HAZARD_FWD_EN
        step(ev(0, 0, 0, 0, 0, 2'd2, 2'd0), "alu_mem_fwd");
`else
        step(BUB, "alu_ex_bubble2");
`endif
        mem_rd = 5'd0; mem_write_en = 1'b0;
        step(NONE, "alu_cleared");

        // rd==0, unused source and non-writing producers are never hazards
        clr();
        ex_rd = 5'd0; ex_write_en = 1'b1; id_rs1 = 5'd0; id_rs1_used = 1'b1;
        mem_rd = 5'd0; mem_write_en = 1'b1;
        step(NONE, "rd_zero");
        clr();
        ex_rd = 5'd9; ex_write_en = 1'b1; id_rs2 = 5'd9; id_rs2_used = 1'b0;
        step(NONE, "unused_src");
        clr();
        ex_rd = 5'd9; ex_write_en = 1'b0; id_rs2 = 5'd9; id_rs2_used = 1'b1;
        step(NONE, "no_write_en");

        // Load-use
        clr();
        ex_rd = 5'd5; ex_write_en = 1'b1; ex_load = 1'b1;
        id_rs1 = 5'd5; id_rs1_used = 1'b1;
        step(ev(1, 1, 0, 0, 1, FWD_EX, 2'd0), "load_use_c0");
        ex_rd = 5'd0; ex_write_en = 1'b0; ex_load = 1'b0;
        mem_rd = 5'd5; mem_write_en = 1'b1;
`ifdef HAZARD_FWD_EN
        step(ev(0, 0, 0, 0, 0, 2'd2, 2'd0), "load_use_c1_fwd");
`else
        step(BUB, "load_use_c1_bubble");
`endif
        clr();
        step(NONE, "load_use_done");

        // Same rd in EX and MEM feeding rs2: EX wins
        ex_rd = 5'd3; ex_write_en = 1'b1; mem_rd = 5'd3; mem_write_en = 1'b1;
        id_rs2 = 5'd3; id_rs2_used = 1'b1;
`ifdef HAZARD_FWD_EN
        step(ev(0, 0, 0, 0, 0, 2'd0, 2'd1), "tie_ex_wins");
`else
        step(BUB, "tie_bubble");
`endif
        // MEM only, random nonzero register
        begin
            logic [4:0] r;
            r = 5'($urandom_range(1, 31));
            clr();
            mem_rd = r; mem_write_en = 1'b1; id_rs2 = r; id_rs2_used = 1'b1;
            step(ev(FWD_MEM == 2'd0, FWD_MEM == 2'd0, 0, 0, FWD_MEM == 2'd0,
                    2'd0, FWD_MEM), "mem_only");
        end

        // mem_busy with branch and load-use present: stalls win, then flush
        clr();
        mem_busy = 1'b1; branch_taken = 1'b1;
        ex_rd = 5'd5; ex_write_en = 1'b1; ex_load = 1'b1;
        id_rs1 = 5'd5; id_rs1_used = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(ev(1, 1, 1, 0, 0, FWD_EX, 2'd0), "busy_stall");
            check_state(2'd1, "busy_state");
            @(posedge clk);
            #1;
        end
        mem_busy = 1'b0;
        step(ev(0, 0, 0, 1, 1, FWD_EX, 2'd0), "busy_release_flush");
        clr();
        step(FL, "busy_flush_c1");
        step(FL, "busy_flush_c2");
        step(NONE, "busy_flush_end");

        // mem_busy during flush abandons the remaining flush
        branch_taken = 1'b1;
        step(FL, "abandon_c0");
        branch_taken = 1'b0;
        mem_busy = 1'b1;
        step(ST, "abandon_busy");
        mem_busy = 1'b0;
        step(NONE, "abandon_done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
